// File: rtl/unidade_busca_pkg.sv
// unidade_busca_pkg: state encoding, opcodes and sizing shared by the fetch unit.
package unidade_busca_pkg;
   localparam int ADDR_W = 7;
   localparam logic [3:0] WDOG_LIMIT = 4'd8;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_IMM     = 3'd3;
   localparam logic [2:0] S_IMM_LAT = 3'd4;
   localparam logic [2:0] S_EXEC    = 3'd5;
   localparam logic [2:0] S_HALT    = 3'd6;
   localparam logic [2:0] OP_MV     = 3'b000;
   localparam logic [2:0] OP_MVI    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b011;
   localparam logic [2:0] OP_MVNZ   = 3'b100;
   localparam logic [2:0] OP_HALT   = 3'b111;
   function automatic logic [2:0] opcode_of(input logic [15:0] w);
      return w[8:6];
   endfunction
endpackage

// File: rtl/unidade_busca_pc.sv
// contador_pc: 7-bit program counter, async active-low clear, wraps modulo 128.
module contador_pc
   import unidade_busca_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);
   logic [ADDR_W-1:0] pc_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) pc_q <= '0;
      else if (inc_i) pc_q <= pc_q + 1'b1;
   assign pc_o = pc_q;
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch FSM with mvi immediate fetch and an EXEC watchdog.
module unidade_busca
   import unidade_busca_pkg::*;
(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   input  logic [15:0] MemData,
   input  logic        Done,
   output logic [6:0]  ADDR,
   output logic [8:0]  Instrucao,
   output logic [15:0] DIN,
   output logic        Run,
   output logic [6:0]  PC,
   output logic        Busy,
   output logic        Halted,
   output logic        Erro
);
   logic [2:0]  state_q, state_d;
   logic [8:0]  instr_q, instr_d;
   logic [15:0] din_q, din_d;
   logic [3:0]  wdog_q, wdog_d;
   logic        run_q, erro_q, erro_d, pc_inc;
   logic [2:0]  opcode;

   assign opcode = opcode_of(MemData);

   contador_pc u_pc (.clk_i(Clock), .rst_ni(Resetn), .inc_i(pc_inc), .pc_o(PC));

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      din_d   = din_q;
      wdog_d  = wdog_q;
      erro_d  = erro_q;
      pc_inc  = 1'b0;
      case (state_q)
         S_IDLE:    state_d = Start ? S_FETCH : S_IDLE;
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            instr_d = MemData[8:0];
            pc_inc  = 1'b1;
            wdog_d  = '0;
            state_d = (opcode == OP_HALT) ? S_HALT : (opcode == OP_MVI) ? S_IMM : S_EXEC;
         end
         S_IMM:     state_d = S_IMM_LAT;
         S_IMM_LAT: begin
            din_d   = MemData;
            pc_inc  = 1'b1;
            wdog_d  = '0;
            state_d = S_EXEC;
         end
         // Done is checked before expiry so a completion in the last allowed cycle is not an error
         S_EXEC: begin
            if (Done) state_d = S_FETCH;
            else if (wdog_q == WDOG_LIMIT - 4'd1) begin
               erro_d  = 1'b1;
               state_d = S_HALT;
            end else wdog_d = wdog_q + 4'd1;
         end
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         din_q   <= '0;
         wdog_q  <= '0;
         erro_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         din_q   <= din_d;
         wdog_q  <= wdog_d;
         erro_q  <= erro_d;
         run_q   <= (state_d == S_EXEC);
      end

   assign ADDR      = PC;
   assign Instrucao = instr_q;
   assign DIN       = din_q;
   assign Run       = run_q;
   assign Erro      = erro_q;
   assign Halted    = (state_q == S_HALT);
   assign Busy      = (state_q != S_IDLE) && (state_q != S_HALT);
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed program runs against a synchronous memory model, with
// per-instruction expectations queued at stimulus time and checked on each Run rise.
module tb_unidade_busca;
   logic        Clock, Resetn, Start, Done;
   logic [15:0] MemData;
   logic [6:0]  ADDR, PC;
   logic [8:0]  Instrucao;
   logic [15:0] DIN;
   logic        Run, Busy, Halted, Erro;

   typedef struct {
      logic [8:0]  ins;
      logic [15:0] din;
      logic [6:0]  pc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem[128];
   int          checks = 0, errors = 0, rises = 0, run_cnt = 0, done_lat = 1;
   logic        done_force = 1'b0, run_prev = 1'b0;

   unidade_busca dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start), .MemData(MemData), .Done(Done),
      .ADDR(ADDR), .Instrucao(Instrucao), .DIN(DIN), .Run(Run), .PC(PC),
      .Busy(Busy), .Halted(Halted), .Erro(Erro)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always_ff @(posedge Clock) MemData <= mem[ADDR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control-unit stand-in: raises Done in the done_lat-th cycle of Run (0 = never)
   initial begin
      Done = 1'b0;
      forever begin
         @(negedge Clock);
         run_cnt = Run ? run_cnt + 1 : 0;
         Done = done_force || (Run && run_cnt == done_lat);
      end
   end

   initial begin
      forever begin
         @(negedge Clock);
         if (Run && !run_prev) begin
            rises++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("run_instr", 32'(Instrucao), 32'(e.ins));
               chk("run_din", 32'(DIN), 32'(e.din));
               chk("run_pc", 32'(PC), 32'(e.pc));
            end
         end
         run_prev = Run;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      chk("sb_drained", 32'(sb.size()), 0);
      Resetn = 1'b0;
      tick();
      tick();
      Resetn = 1'b1;
      tick();
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic wait_run(output int n);
      n = 1;
      while (!Run && n < 30) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_halt(input int budget, output int k);
      k = 0;
      while (!Halted && k < budget) begin
         tick();
         k++;
      end
   endtask

   initial begin
      int n, k, r0;
      logic [6:0] prev;
      Start  = 1'b0;
      Resetn = 1'b1;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
      #2 Resetn = 1'b0;
      tick();
      tick();
      chk("rst_pc", 32'(PC), 0);
      chk("rst_addr", 32'(ADDR), 0);
      chk("rst_instr", 32'(Instrucao), 0);
      chk("rst_din", 32'(DIN), 0);
      chk("rst_run", 32'(Run), 0);
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_halted", 32'(Halted), 0);
      chk("rst_erro", 32'(Erro), 0);
      Resetn = 1'b1;
      tick();
      tick();
      chk("idle_hold", 32'(Busy), 0);

      // mv R1,R2 then HALT
      mem[0] = 16'h000A;
      mem[1] = 16'h01C0;
      sb.push_back('{9'h00A, 16'h0000, 7'd1});
      r0 = rises;
      pulse_start();
      chk("fetch_busy", 32'(Busy), 1);
      wait_run(n);
      chk("mv_latency", n, 3);
      tick();
      chk("mv_back_run", 32'(Run), 0);
      chk("mv_back_busy", 32'(Busy), 1);
      chk("mv_back_pc", 32'(PC), 1);
      chk("mv_back_instr", 32'(Instrucao), 32'h00A);
      wait_halt(20, k);
      chk("mv_halted", 32'(Halted), 1);
      chk("mv_one_pulse", rises - r0, 1);
      chk("mv_halt_pc", 32'(PC), 2);

      // mvi R3 with immediate, then a mv that must leave DIN alone
      do_reset();
      mem[0] = 16'h0058;
      mem[1] = 16'h00A5;
      mem[2] = 16'h000A;
      mem[3] = 16'h01C0;
      sb.push_back('{9'h058, 16'h00A5, 7'd2});
      sb.push_back('{9'h00A, 16'h00A5, 7'd3});
      pulse_start();
      wait_run(n);
      chk("mvi_latency", n, 5);
      chk("mvi_din", 32'(DIN), 32'h00A5);
      chk("mvi_pc", 32'(PC), 2);
      wait_halt(30, k);
      chk("mvi_halted", 32'(Halted), 1);
      chk("mvi_din_hold", 32'(DIN), 32'h00A5);

      // Done withheld: watchdog expires after 8 EXEC cycles
      do_reset();
      done_lat = 0;
      mem[0] = 16'h000A;
      sb.push_back('{9'h00A, 16'h0000, 7'd1});
      pulse_start();
      wait_run(n);
      wait_halt(20, k);
      chk("wdog_cycles", k, 8);
      chk("wdog_erro", 32'(Erro), 1);
      chk("wdog_halted", 32'(Halted), 1);
      chk("wdog_run", 32'(Run), 0);
      chk("wdog_busy", 32'(Busy), 0);

      // Done in the 8th EXEC cycle wins over expiry
      do_reset();
      chk("erro_cleared", 32'(Erro), 0);
      done_lat = 8;
      mem[0] = 16'h000A;
      mem[1] = 16'h01C0;
      sb.push_back('{9'h00A, 16'h0000, 7'd1});
      pulse_start();
      wait_halt(40, k);
      chk("late_done_erro", 32'(Erro), 0);
      chk("late_done_pc", 32'(PC), 2);
      chk("late_done_instr", 32'(Instrucao), 32'h1C0);
      done_lat = 1;

      // Walk the full address space with mv instructions to see the PC wrap
      do_reset();
      for (int i = 0; i < 128; i++) begin
         mem[i] = 16'(i % 64);
         sb.push_back('{9'(i % 64), 16'h0000, 7'((i + 1) % 128)});
      end
      pulse_start();
      prev = PC;
      k = 0;
      while (!(prev == 7'd127 && PC == 7'd0) && k < 600) begin
         prev = PC;
         tick();
         k++;
      end
      chk("wrap_pc", 32'(PC), 0);
      chk("wrap_addr", 32'(ADDR), 0);
      chk("wrap_seen", 32'(prev), 127);
      chk("wrap_erro", 32'(Erro), 0);
      tick();

      // Asynchronous reset while the second mvi is in S_IMM_LAT
      do_reset();
      mem[0] = 16'h0058;
      mem[1] = 16'hBEEF;
      mem[2] = 16'h0058;
      mem[3] = 16'h1234;
      sb.push_back('{9'h058, 16'hBEEF, 7'd2});
      pulse_start();
      wait_run(n);
      repeat (4) tick();
      chk("imm_lat_pc", 32'(PC), 3);
      chk("imm_lat_din", 32'(DIN), 32'hBEEF);
      Resetn = 1'b0;
      #1;
      chk("arst_pc", 32'(PC), 0);
      chk("arst_addr", 32'(ADDR), 0);
      chk("arst_instr", 32'(Instrucao), 0);
      chk("arst_din", 32'(DIN), 0);
      chk("arst_busy", 32'(Busy), 0);
      chk("arst_run", 32'(Run), 0);
      tick();
      Resetn = 1'b1;
      tick();
      tick();
      chk("arst_idle", 32'(Busy), 0);
      mem[0] = 16'h000A;
      mem[1] = 16'h01C0;
      sb.push_back('{9'h00A, 16'h0000, 7'd1});
      pulse_start();
      wait_halt(20, k);
      chk("restart_pc", 32'(PC), 2);

      // HALT at address 2: no Run for it, Start and Done ignored until Resetn
      do_reset();
      mem[0] = 16'h000A;
      mem[1] = 16'h0011;
      mem[2] = 16'h01C0;
      sb.push_back('{9'h00A, 16'h0000, 7'd1});
      sb.push_back('{9'h011, 16'h0000, 7'd2});
      r0 = rises;
      pulse_start();
      wait_halt(30, k);
      chk("halt_flag", 32'(Halted), 1);
      chk("halt_busy", 32'(Busy), 0);
      chk("halt_pc", 32'(PC), 3);
      chk("halt_rises", rises - r0, 2);
      Start = 1'b1;
      done_force = 1'b1;
      repeat (4) tick();
      Start = 1'b0;
      done_force = 1'b0;
      chk("halt_sticky", 32'(Halted), 1);
      chk("halt_run", 32'(Run), 0);
      chk("halt_pc_hold", 32'(PC), 3);
      Resetn = 1'b0;
      #1;
      chk("halt_rst", 32'(Halted), 0);
      tick();
      Resetn = 1'b1;
      tick();
      chk("halt_rst_idle", 32'(Busy), 0);
      chk("sb_final", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
